// File: rtl/mem_fill_arbiter_if.sv
// Handshake bundle between the two cache miss handlers, the fill arbiter and
// the multi-cycle backing memory.
interface mem_fill_arbiter_if #(
    parameter int WORDS_PER_BLOCK = 8
);
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

    logic             i_miss_req;
    logic [15:0]      i_miss_addr;
    logic             d_miss_req;
    logic [15:0]      d_miss_addr;
    logic             mem_en;
    logic [15:0]      mem_addr;
    logic             mem_data_valid;
    logic [15:0]      mem_data;
    logic             fill_valid;
    logic [15:0]      fill_data;
    logic [IDX_W-1:0] fill_word;
    logic             fill_to_d;
    logic             i_busy;
    logic             d_busy;
    logic             i_fill_done;
    logic             d_fill_done;

    // The arbiter side
    modport master (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        input  mem_data_valid, mem_data,
        output mem_en, mem_addr,
        output fill_valid, fill_data, fill_word, fill_to_d,
        output i_busy, d_busy, i_fill_done, d_fill_done
    );

    // The cache controllers plus memory model side
    modport slave (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        output mem_data_valid, mem_data,
        input  mem_en, mem_addr,
        input  fill_valid, fill_data, fill_word, fill_to_d,
        input  i_busy, d_busy, i_fill_done, d_fill_done
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D cache misses onto one backing memory and sequences each block
// fill: back-to-back word requests, latency-delayed returns, then a done strobe.
module mem_fill_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_fill_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] BLOCK_WORDS = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [15:0]      BLOCK_MASK  = ~16'(2 * WORDS_PER_BLOCK - 1);

    generate
        if (WORDS_PER_BLOCK < 2 || WORDS_PER_BLOCK > 16 ||
            (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 || MEM_LATENCY < 1) begin : g_bad_params
            $error("mem_fill_arbiter: unsupported WORDS_PER_BLOCK/MEM_LATENCY");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner_d;
    logic [15:0]      base;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] addr_cnt;
    logic             grant;
    logic             grant_d;
    logic             issue_active;
    logic             word_ret;

    assign issue_active = (state == FILL) && (issue_cnt < BLOCK_WORDS);
    assign word_ret     = (state == FILL) && bus.mem_data_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // D has fixed priority; DONE never arbitrates so a held request is seen fresh in IDLE
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d_miss_req) begin
                    grant      = 1'b1;
                    grant_d    = 1'b1;
                    state_next = FILL;
                end else if (bus.i_miss_req) begin
                    grant      = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (word_ret && ret_cnt == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d   <= 1'b0;
            base      <= 16'h0000;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (grant) begin
            owner_d   <= grant_d;
            base      <= (grant_d ? bus.d_miss_addr : bus.i_miss_addr) & BLOCK_MASK;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (issue_active) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (word_ret) begin
                ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end

    // Once every word is issued the address sticks at the last one requested
    assign addr_cnt = (issue_cnt == BLOCK_WORDS) ? LAST_IDX : issue_cnt;

    assign bus.mem_en      = issue_active;
    assign bus.mem_addr    = base + {{(15 - IDX_W){1'b0}}, addr_cnt[IDX_W-1:0], 1'b0};
    assign bus.fill_valid  = word_ret;
    assign bus.fill_data   = bus.mem_data;
    assign bus.fill_word   = ret_cnt[IDX_W-1:0];
    assign bus.fill_to_d   = (state != IDLE) && owner_d;
    assign bus.i_busy      = (state != IDLE) && !owner_d;
    assign bus.d_busy      = (state != IDLE) && owner_d;
    assign bus.i_fill_done = (state == DONE) && !owner_d;
    assign bus.d_fill_done = (state == DONE) && owner_d;
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter: a default instance (8 words, latency 4)
// and a small one (4 words, latency 1), each fed by its own memory model.
module tb_mem_fill_arbiter;
    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        spur_v;
    logic [15:0] spur_d;
    logic        sel4;

    int assert_count = 0;
    int fail_count   = 0;

    mem_fill_arbiter_if #(.WORDS_PER_BLOCK(8)) bus8 ();
    mem_fill_arbiter_if #(.WORDS_PER_BLOCK(4)) bus4 ();

    mem_fill_arbiter #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    mem_fill_arbiter #(.WORDS_PER_BLOCK(4), .MEM_LATENCY(1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    assign bus8.i_miss_req  = i_req;
    assign bus8.i_miss_addr = i_addr;
    assign bus8.d_miss_req  = d_req;
    assign bus8.d_miss_addr = d_addr;
    assign bus4.i_miss_req  = i_req;
    assign bus4.i_miss_addr = i_addr;
    assign bus4.d_miss_req  = d_req;
    assign bus4.d_miss_addr = d_addr;

    // Memory models ignore reset so words from an aborted fill still come back
    logic [3:0]  pv8 = '0;
    logic [15:0] pa8 [4];
    logic        pv4 = 1'b0;
    logic [15:0] pa4 = 16'h0000;

    always @(posedge clk) begin
        pv8 <= {pv8[2:0], bus8.mem_en};
        for (int k = 3; k > 0; k--) pa8[k] <= pa8[k-1];
        pa8[0] <= bus8.mem_addr;
        pv4 <= bus4.mem_en;
        pa4 <= bus4.mem_addr;
    end

    assign bus8.mem_data_valid = pv8[3] | spur_v;
    assign bus8.mem_data       = spur_v ? spur_d : data_of(pa8[3]);
    assign bus4.mem_data_valid = pv4;
    assign bus4.mem_data       = data_of(pa4);

    logic        obs_mem_en;
    logic [15:0] obs_mem_addr;
    logic        obs_fill_valid;
    logic [15:0] obs_fill_data;
    logic [3:0]  obs_fill_word;
    logic        obs_fill_to_d;
    logic [1:0]  obs_busy;
    logic [1:0]  obs_done;

    always_comb begin
        obs_mem_en     = bus8.mem_en;
        obs_mem_addr   = bus8.mem_addr;
        obs_fill_valid = bus8.fill_valid;
        obs_fill_data  = bus8.fill_data;
        obs_fill_word  = {1'b0, bus8.fill_word};
        obs_fill_to_d  = bus8.fill_to_d;
        obs_busy       = {bus8.i_busy, bus8.d_busy};
        obs_done       = {bus8.i_fill_done, bus8.d_fill_done};
        if (sel4) begin
            obs_mem_en     = bus4.mem_en;
            obs_mem_addr   = bus4.mem_addr;
            obs_fill_valid = bus4.fill_valid;
            obs_fill_data  = bus4.fill_data;
            obs_fill_word  = {2'b00, bus4.fill_word};
            obs_fill_to_d  = bus4.fill_to_d;
            obs_busy       = {bus4.i_busy, bus4.d_busy};
            obs_done       = {bus4.i_fill_done, bus4.d_fill_done};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit is_d, input logic [15:0] addr);
        if (is_d) begin
            d_addr = addr;
            d_req  = 1'b1;
        end else begin
            i_addr = addr;
            i_req  = 1'b1;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " mem_en"},     obs_mem_en,     1'b0);
        checkOutput({tag, " mem_addr"},   obs_mem_addr,   16'h0000);
        checkOutput({tag, " fill_valid"}, obs_fill_valid, 1'b0);
        checkOutput({tag, " fill_word"},  obs_fill_word,  4'd0);
        checkOutput({tag, " fill_to_d"},  obs_fill_to_d,  1'b0);
        checkOutput({tag, " busy"},       obs_busy,       2'b00);
        checkOutput({tag, " done"},       obs_done,       2'b00);
    endtask

    // Called in the cycle whose closing edge samples the request (E0); walks
    // cycles 1 .. done+1 and drops the owner's request after checking drop_c.
    task automatic observeFill(input bit exp_d, input logic [15:0] base,
                               input int nw, input int lat, input int drop_c);
        int         done_c;
        logic [1:0] own;
        done_c = nw + lat + 1;
        own    = exp_d ? 2'b01 : 2'b10;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(posedge clk);
            #1;
            checkOutput("mem_en", obs_mem_en, (c <= nw));
            if (c <= nw)
                checkOutput("mem_addr", obs_mem_addr, base + 16'(2 * (c - 1)));
            else if (c <= done_c)
                checkOutput("mem_addr hold", obs_mem_addr, base + 16'(2 * (nw - 1)));
            checkOutput("fill_valid", obs_fill_valid, (c > lat && c <= nw + lat));
            if (c > lat && c <= nw + lat) begin
                checkOutput("fill_word", obs_fill_word, c - lat - 1);
                checkOutput("fill_data", obs_fill_data, data_of(base + 16'(2 * (c - lat - 1))));
                checkOutput("fill_to_d", obs_fill_to_d, exp_d);
            end
            checkOutput("busy", obs_busy, (c <= done_c) ? own : 2'b00);
            checkOutput("done", obs_done, (c == done_c) ? own : 2'b00);
            if (c == drop_c) begin
                if (exp_d) d_req = 1'b0;
                else       i_req = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        i_req  = 1'b0;
        d_req  = 1'b0;
        i_addr = 16'h0000;
        d_addr = 16'h0000;
        spur_v = 1'b0;
        spur_d = 16'h0000;
        sel4   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single I-miss");
        applyStimulus(1'b0, 16'h1236);
        observeFill(1'b0, 16'h1230, 8, 4, 13);

        $display("[TB] simultaneous I and D miss");
        applyStimulus(1'b1, 16'h4008);
        applyStimulus(1'b0, 16'h0010);
        observeFill(1'b1, 16'h4000, 8, 4, 13);
        observeFill(1'b0, 16'h0010, 8, 4, 13);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 16'hFFFA);
        observeFill(1'b1, 16'hFFF0, 8, 4, 13);

        $display("[TB] reset mid-fill");
        applyStimulus(1'b0, 16'h2000);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        checkIdleOutputs("mid-fill reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checkOutput("stale fill_valid", obs_fill_valid, 1'b0);
            checkOutput("stale done", obs_done, 2'b00);
            checkOutput("stale mem_en", obs_mem_en, 1'b0);
        end
        applyStimulus(1'b0, 16'h2ABC);
        observeFill(1'b0, 16'h2AB0, 8, 4, 13);

        $display("[TB] spurious data and early drop");
        spur_d = 16'hBEEF;
        spur_v = 1'b1;
        #1;
        checkOutput("spurious fill_valid", obs_fill_valid, 1'b0);
        @(posedge clk);
        #1;
        spur_v = 1'b0;
        checkOutput("spurious busy", obs_busy, 2'b00);
        applyStimulus(1'b0, 16'h0A0E);
        observeFill(1'b0, 16'h0A00, 8, 4, 3);

        $display("[TB] 4-word block, latency 1");
        repeat (10) @(posedge clk);
        #1;
        sel4 = 1'b1;
        checkOutput("small idle busy", obs_busy, 2'b00);
        applyStimulus(1'b0, 16'h0106);
        observeFill(1'b0, 16'h0100, 4, 1, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
